// File: rtl/dram_arbiter_if.sv
// Port bundle between the data-RAM arbiter, its two requesters and the RAM itself.
// The arbiter connects through the slave modport; the environment connects through master.
interface dram_arbiter_if #(
  parameter int BURST_W = 4
) ();
  logic               m0_req;
  logic               m0_we;
  logic [31:0]        m0_addr;
  logic [3:0]         m0_sel;
  logic [31:0]        m0_wdata;
  logic [31:0]        m0_rdata;
  logic               m0_ack;
  logic               stall_req;

  logic               m1_req;
  logic               m1_we;
  logic [31:0]        m1_addr;
  logic [BURST_W-1:0] m1_len;
  logic [31:0]        m1_wdata;
  logic               m1_wnext;
  logic [31:0]        m1_rdata;
  logic               m1_rvalid;
  logic               m1_done;

  logic               ram_ce;
  logic               ram_we;
  logic [31:0]        ram_addr;
  logic [3:0]         ram_sel;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    output m0_rdata, m0_ack, stall_req,
    input  m1_req, m1_we, m1_addr, m1_len, m1_wdata,
    output m1_wnext, m1_rdata, m1_rvalid, m1_done,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    input  m0_rdata, m0_ack, stall_req,
    output m1_req, m1_we, m1_addr, m1_len, m1_wdata,
    input  m1_wnext, m1_rdata, m1_rvalid, m1_done,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port arbiter for the single-ported data RAM: zero-latency single accesses for the
// MEM stage (port 0) and non-preemptible word bursts for the DMA/loader engine (port 1).
module dram_arbiter #(
  parameter int BURST_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dram_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]         state_r;
  logic               last_grant_r;
  logic [BURST_W-1:0] cnt_r;
  logic [BURST_W-1:0] len_r;
  logic [31:0]        base_r;
  logic               dir_r;

  logic               grant_m0_s;
  logic               grant_m1_s;
  logic               last_beat_s;
  logic [31:0]        offset_s;

  // Round-robin grant in IDLE; held off while reset is asserted so nothing reaches the RAM.
  always_comb begin
    grant_m0_s  = 1'b0;
    grant_m1_s  = 1'b0;
    if (rst_n && (state_r == ST_IDLE)) begin
      grant_m0_s = bus.m0_req && (!bus.m1_req || last_grant_r);
      grant_m1_s = bus.m1_req && (!bus.m0_req || !last_grant_r);
    end else begin
      grant_m0_s = 1'b0;
      grant_m1_s = 1'b0;
    end
    last_beat_s = (cnt_r == len_r);
    offset_s    = {{(30-BURST_W){1'b0}}, cnt_r, 2'b00};
  end

  // RAM bus and port output steering; exactly one owner of ram_* per cycle.
  always_comb begin
    bus.ram_ce    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = 32'h0000_0000;
    bus.ram_sel   = 4'h0;
    bus.ram_wdata = 32'h0000_0000;
    bus.m0_rdata  = 32'h0000_0000;
    bus.m0_ack    = 1'b0;
    bus.m1_wnext  = 1'b0;
    bus.m1_rdata  = 32'h0000_0000;
    bus.m1_rvalid = 1'b0;
    bus.m1_done   = 1'b0;
    if (state_r == ST_BURST) begin
      bus.ram_ce   = 1'b1;
      bus.ram_we   = dir_r;
      bus.ram_sel  = 4'hF;
      bus.ram_addr = base_r + offset_s;
      bus.m1_done  = last_beat_s;
      if (dir_r) begin
        bus.ram_wdata = bus.m1_wdata;
        bus.m1_wnext  = 1'b1;
      end else begin
        bus.m1_rdata  = bus.ram_rdata;
        bus.m1_rvalid = 1'b1;
      end
    end else if (grant_m0_s) begin
      bus.ram_ce    = 1'b1;
      bus.ram_we    = bus.m0_we;
      bus.ram_addr  = bus.m0_addr;
      bus.ram_sel   = bus.m0_sel;
      bus.ram_wdata = bus.m0_wdata;
      bus.m0_rdata  = bus.ram_rdata;
      bus.m0_ack    = 1'b1;
    end else begin
      bus.ram_ce    = 1'b0;
    end
    bus.stall_req = bus.m0_req && !bus.m0_ack;
  end

  // Sequencer state: grant history, burst acceptance and beat counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      cnt_r        <= '0;
      len_r        <= '0;
      base_r       <= 32'h0000_0000;
      dir_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_m0_s) begin
            last_grant_r <= 1'b0;
          end else if (grant_m1_s) begin
            base_r       <= {bus.m1_addr[31:2], 2'b00};
            len_r        <= bus.m1_len;
            dir_r        <= bus.m1_we;
            cnt_r        <= '0;
            last_grant_r <= 1'b1;
            state_r      <= ST_BURST;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (last_beat_s) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_r + {{(BURST_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: 1 KiB RAM model, hand-computed expectations.
module tb_dram_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] mem [0:255] = '{default: 32'h0000_0000};

  dram_arbiter_if #(.BURST_W(4)) bus ();

  dram_arbiter #(.BURST_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read RAM with byte-lane writes on the rising edge
  always_comb bus.ram_rdata = mem[bus.ram_addr[9:2]];

  always @(posedge clk) begin
    if (bus.ram_ce && bus.ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_sel[b]) mem[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_sel = 4'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_len = 4'd0; bus.m1_wdata = 32'h0;

    // Reset: RAM bus idle, stall follows a held m0_req
    @(negedge clk);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd1);
    chk("rst_ce", {31'd0, bus.ram_ce}, 32'd0);
    chk("rst_ack", {31'd0, bus.m0_ack}, 32'd0);
    chk("rst_addr", bus.ram_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.m0_req = 1'b0;
    tick();

    // m0 full-word write then read
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h10; bus.m0_sel = 4'hF; bus.m0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("m0_wr_ack", {31'd0, bus.m0_ack}, 32'd1);
    chk("m0_wr_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("m0_wr_addr", bus.ram_addr, 32'h10);
    tick();
    bus.m0_we = 1'b0;
    @(negedge clk);
    chk("m0_rd_ack", {31'd0, bus.m0_ack}, 32'd1);
    chk("m0_rd_data", bus.m0_rdata, 32'hDEADBEEF);
    tick();

    // m0 partial write of byte lane 1
    bus.m0_we = 1'b1; bus.m0_sel = 4'b0010; bus.m0_wdata = 32'h0000AB00;
    @(negedge clk);
    chk("m0_pw_ack", {31'd0, bus.m0_ack}, 32'd1);
    tick();
    bus.m0_we = 1'b0;
    @(negedge clk);
    chk("m0_pw_data", bus.m0_rdata, 32'hDEADABEF);
    tick();
    bus.m0_req = 1'b0;

    // m1 write burst of 4 beats at 0x20
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h20; bus.m1_len = 4'd3; bus.m1_wdata = 32'd1;
    @(negedge clk);
    chk("m1w_acc_ce", {31'd0, bus.ram_ce}, 32'd0);
    chk("m1w_acc_wnext", {31'd0, bus.m1_wnext}, 32'd0);
    tick();
    bus.m1_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.m1_wdata = 32'(i + 1);
      @(negedge clk);
      chk("m1w_wnext", {31'd0, bus.m1_wnext}, 32'd1);
      chk("m1w_addr", bus.ram_addr, 32'h20 + 32'(4 * i));
      chk("m1w_wdata", bus.ram_wdata, 32'(i + 1));
      chk("m1w_done", {31'd0, bus.m1_done}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("m1w_after_done", {31'd0, bus.m1_done}, 32'd0);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bus.m0_addr = 32'h20 + 32'(4 * i);
      @(negedge clk);
      chk("m1w_readback", bus.m0_rdata, 32'(i + 1));
      tick();
    end
    bus.m0_req = 1'b0;

    // 16-beat read burst with m0 raised on the accept cycle (m1 wins the tie)
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h23; bus.m1_len = 4'd15;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h24;
    @(negedge clk);
    chk("rb_acc_ack", {31'd0, bus.m0_ack}, 32'd0);
    chk("rb_acc_stall", {31'd0, bus.stall_req}, 32'd1);
    tick();
    bus.m1_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rb_stall", {31'd0, bus.stall_req}, 32'd1);
      chk("rb_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
      chk("rb_addr", bus.ram_addr, 32'h20 + 32'(4 * i));
      chk("rb_rdata", bus.m1_rdata, (i < 4) ? 32'(i + 1) : 32'd0);
      chk("rb_done", {31'd0, bus.m1_done}, (i == 15) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk);
    chk("rb_m0_ack", {31'd0, bus.m0_ack}, 32'd1);
    chk("rb_m0_data", bus.m0_rdata, 32'd2);
    chk("rb_m0_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();
    bus.m0_req = 1'b0;

    // Round-robin from reset: m0, m1, m0, m1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h20;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h28; bus.m1_len = 4'd0;
    @(negedge clk);
    chk("rr1_m0", {31'd0, bus.m0_ack}, 32'd1);
    tick();
    @(negedge clk);
    chk("rr2_m1", {30'd0, bus.m0_ack, bus.ram_ce}, 32'd0);
    tick();
    @(negedge clk);
    chk("rr2_beat", bus.m1_rdata, 32'd3);
    chk("rr2_done", {31'd0, bus.m1_done}, 32'd1);
    tick();
    @(negedge clk);
    chk("rr3_m0", {31'd0, bus.m0_ack}, 32'd1);
    tick();
    @(negedge clk);
    chk("rr4_m1", {30'd0, bus.m0_ack, bus.ram_ce}, 32'd0);
    tick();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    @(negedge clk);
    chk("rr4_done", {31'd0, bus.m1_done}, 32'd1);
    tick();

    // Address wrap, then reset mid-burst
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'hFFFFFFF8; bus.m1_len = 4'd3;
    tick();
    bus.m1_req = 1'b0;
    @(negedge clk);
    chk("wrap_b0", bus.ram_addr, 32'hFFFFFFF8);
    tick();
    @(negedge clk);
    chk("wrap_b1", bus.ram_addr, 32'hFFFFFFFC);
    tick();
    @(negedge clk);
    chk("wrap_b2", bus.ram_addr, 32'h00000000);
    tick();
    chk("wrap_b3", bus.ram_addr, 32'h00000004);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ce", {31'd0, bus.ram_ce}, 32'd0);
    chk("abort_done", {31'd0, bus.m1_done}, 32'd0);
    chk("abort_addr", bus.ram_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_ce", {31'd0, bus.ram_ce}, 32'd0);
    tick();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h2C;
    @(negedge clk);
    chk("post_rst_m0_ack", {31'd0, bus.m0_ack}, 32'd1);
    chk("post_rst_m0_data", bus.m0_rdata, 32'd4);
    tick();
    bus.m0_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
